mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Single-master bus front end that shares one external memory bus between instruction fetch (driven by the PC stage) and the MEM-stage data port. It sequences each access as a bus transaction and returns read data to the requester. It raises per-requester stall requests toward the pipeline controller until data is delivered. It also absorbs pipeline stalls and flushes so that no bus cycle is torn or lost, and it bounds every access with a timeout.

## Interface
Parameters:
- TMO_CYCLES, 255, cycles allowed from strobe to ack before the access is force-completed (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stall_i  in  6  pipeline stall vector from the controller; bit 0 is the PC stage
- flush_i  in  1  pipeline flush (exception or return)
- if_req_i  in  1  fetch request (PC chip enable)
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction
- if_stallreq_o  out  1  fetch not yet delivered
- dm_req_i  in  1  data access request
- dm_we_i  in  1  1 = store
- dm_sel_i  in  4  byte lane select
- dm_addr_i  in  32  data address
- dm_wdata_i  in  32  store data
- dm_rdata_o  out  32  load data
- dm_stallreq_o  out  1  data access not yet complete
- bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  bus cycle, strobe, write
- bus_sel_o  out  4  byte lanes
- bus_adr_o, bus_dat_o  out  32 each  address, write data
- bus_dat_i  in  32  read data
- bus_ack_i  in  1  slave acknowledge; may be combinational with stb
- tmo_o  out  1  one-cycle pulse when a timeout occurs

## Operation
- States: IDLE, DM_BUSY, IF_BUSY, DM_WAIT, IF_WAIT, IF_DRAIN.
- IDLE behaviour:
  - dm_req_i has priority over if_req_i.
  - A granted request registers bus_adr, sel, we and dat, and sets cyc and stb; the FSM moves to DM_BUSY or IF_BUSY.
  - A fetch is not granted while flush_i = 1.
  - Fetch uses sel = 4'hF and we = 0.
- DM_BUSY or IF_BUSY plus bus_ack_i:
  - Capture bus_dat_i into the requester's read buffer and drop cyc/stb at that edge.
  - If stall_i != 0, go to the matching *_WAIT state. Otherwise go to IDLE.
- *_WAIT: hold the buffer. Go to IDLE when stall_i == 0 or flush_i = 1. On flush the buffer is discarded, and if_rdata_o reads 0 afterwards.
- Flush during IF_BUSY: go to IF_DRAIN, keeping cyc/stb asserted until ack. The ack is discarded and the FSM goes to IDLE. if_stallreq_o stays low throughout the drain.
- Flush during DM_BUSY: the access completes normally. A started store is never aborted.
- Timeout:
  - An 8-bit counter clears on strobe and increments each BUSY or DRAIN cycle without ack.
  - When the count reaches TMO_CYCLES with no ack, the access is completed as if acked with read data 32'h0. cyc/stb drop and tmo_o pulses once.
- Stall requests (combinational):
  - if_stallreq_o = if_req_i & ~flush_i & ~(state==IF_BUSY & ack) & state∉{IF_WAIT, IF_DRAIN}.
  - dm_stallreq_o = dm_req_i & ~(state==DM_BUSY & ack) & state≠DM_WAIT.
- Read data: during a BUSY state with ack, if_rdata_o / dm_rdata_o bypass bus_dat_i. Otherwise they show the buffer.

## Timing
- Reset: state IDLE and the timeout counter at 0. All outputs 0: bus_*, tmo_o, buffers, rdata. Both stallreqs are 0 while rst = 1.
- Reset mid-transaction drops cyc/stb on the next edge without waiting for ack.
- Request seen in IDLE at cycle N gives cyc/stb at N+1. The earliest ack is at N+1, with data and stallreq release in the same cycle.
- Minimum cost is one stall cycle per access. The bus is idle for at least one cycle between consecutive transactions.
- Both requests present in IDLE: the data access goes first and the fetch follows. The fetch stalls for at least 3 cycles with zero-wait-state memory.
- Ack and timeout in the same cycle: ack wins, tmo_o stays 0.
- Ack and flush in the same IF_BUSY cycle: the data is discarded and the FSM goes to IDLE, not to IF_DRAIN.

## Structure
- Defines.vh holds:
  - the state encodings (3-bit localparams as `define),
  - TMO width,
  - reuse of `InstAddrBus, `RegBus, `Enable and `ZeroWord.
- One sub-module, bus_tmo_cnt: counter with clear, enable and expire outputs. Everything else is a single FSM plus buffer registers in mem_bus_arbiter.

## Test plan
- Fetch 0x0000_0100 with a zero-wait slave returning 0x2408_0001:
  - cyc/stb appear 1 cycle after the request,
  - if_rdata_o = 0x2408_0001 with if_stallreq_o low in the ack cycle,
  - the bus is idle on the next cycle.
- if_req and dm store (addr 0x80, data 0xDEAD_BEEF, sel 4'hF) asserted together:
  - the store is issued first with bus_we_o = 1,
  - the fetch is issued after one idle cycle,
  - if_stallreq_o stays high until the fetch ack.
- Fetch ack while stall_i = 6'b000011:
  - the FSM enters IF_WAIT and holds the data with if_stallreq_o low,
  - stall_i goes to 0 and the FSM returns to IDLE.
- flush_i asserted one cycle into a fetch whose slave acks after 3 cycles:
  - cyc/stb stay high until the ack,
  - the data is discarded, if_stallreq_o is low, and no new fetch starts until flush_i falls.
- Slave never acks with TMO_CYCLES = 4:
  - after 4 cycles stb drops, tmo_o pulses one cycle, dm_rdata_o = 0 and dm_stallreq_o releases.
- rst asserted during DM_BUSY: all outputs are 0 at the next edge and the FSM is in IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the memory bus arbiter: FSM states and the registered bus request payload.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned TMO_W   = 8;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [SEL_W-1:0]  SEL_ALL   = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DM_BUSY  = 3'd1,
        ST_IF_BUSY  = 3'd2,
        ST_DM_WAIT  = 3'd3,
        ST_IF_WAIT  = 3'd4,
        ST_IF_DRAIN = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_tmo_cnt.sv
// Bus access timeout counter: cleared when a strobe is issued, counts unacked busy cycles.
module mem_bus_arbiter_tmo_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c
);

    localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // The cycle that would take the count to TMO_CYCLES is the one that force-completes.
    assign expire_c = en_i & (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM-stage data port,
// returning read data and raising stall requests until each access is delivered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_stallreq_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_stallreq_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic        tmo_o
);

    arb_state_e        state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              cyc_q, cyc_d;
    logic              tmo_q, tmo_d;
    logic [DATA_W-1:0] if_buf_q, if_buf_d;
    logic [DATA_W-1:0] dm_buf_q, dm_buf_d;

    logic              busy_c;
    logic              cnt_clr_c;
    logic              expire_c;
    logic              done_c;
    logic              stalled_c;
    logic [DATA_W-1:0] rdata_c;

    assign busy_c    = (state_q == ST_DM_BUSY) | (state_q == ST_IF_BUSY) | (state_q == ST_IF_DRAIN);
    assign stalled_c = |stall_i;
    // A timed-out access completes exactly like an acked one, with zero read data.
    assign done_c    = busy_c & (bus_ack_i | expire_c);
    assign rdata_c   = bus_ack_i ? bus_dat_i : ZERO_WORD;

    mem_bus_arbiter_tmo_cnt #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr_c),
        .en_i     (busy_c & ~bus_ack_i),
        .expire_c (expire_c)
    );

    // Next-state, bus request and read buffer update.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cyc_d     = cyc_q;
        tmo_d     = 1'b0;
        if_buf_d  = if_buf_q;
        dm_buf_d  = dm_buf_q;
        cnt_clr_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dm_req_i) begin
                    state_d   = ST_DM_BUSY;
                    req_d.we  = dm_we_i;
                    req_d.sel = dm_sel_i;
                    req_d.adr = dm_addr_i;
                    req_d.dat = dm_wdata_i;
                    cyc_d     = 1'b1;
                    cnt_clr_c = 1'b1;
                end else if (if_req_i && !flush_i) begin
                    state_d   = ST_IF_BUSY;
                    req_d.we  = 1'b0;
                    req_d.sel = SEL_ALL;
                    req_d.adr = if_addr_i;
                    req_d.dat = ZERO_WORD;
                    cyc_d     = 1'b1;
                    cnt_clr_c = 1'b1;
                end
            end

            // A started data access always runs to completion, flush or not.
            ST_DM_BUSY: begin
                if (done_c) begin
                    cyc_d    = 1'b0;
                    tmo_d    = ~bus_ack_i;
                    dm_buf_d = rdata_c;
                    state_d  = stalled_c ? ST_DM_WAIT : ST_IDLE;
                end
            end

            ST_IF_BUSY: begin
                if (done_c) begin
                    cyc_d = 1'b0;
                    tmo_d = ~bus_ack_i;
                    if (flush_i) begin
                        if_buf_d = ZERO_WORD;
                        state_d  = ST_IDLE;
                    end else begin
                        if_buf_d = rdata_c;
                        state_d  = stalled_c ? ST_IF_WAIT : ST_IDLE;
                    end
                end else if (flush_i) begin
                    if_buf_d = ZERO_WORD;
                    state_d  = ST_IF_DRAIN;
                end
            end

            // Keep the cycle open until the slave answers, then throw the data away.
            ST_IF_DRAIN: begin
                if (done_c) begin
                    cyc_d   = 1'b0;
                    tmo_d   = ~bus_ack_i;
                    state_d = ST_IDLE;
                end
            end

            ST_DM_WAIT: begin
                if (flush_i) begin
                    dm_buf_d = ZERO_WORD;
                    state_d  = ST_IDLE;
                end else if (!stalled_c) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IF_WAIT: begin
                if (flush_i) begin
                    if_buf_d = ZERO_WORD;
                    state_d  = ST_IDLE;
                end else if (!stalled_c) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            cyc_q    <= 1'b0;
            tmo_q    <= 1'b0;
            if_buf_q <= '0;
            dm_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cyc_q    <= cyc_d;
            tmo_q    <= tmo_d;
            if_buf_q <= if_buf_d;
            dm_buf_q <= dm_buf_d;
        end
    end

    assign bus_cyc_o = cyc_q;
    assign bus_stb_o = cyc_q;
    assign bus_we_o  = req_q.we;
    assign bus_sel_o = req_q.sel;
    assign bus_adr_o = req_q.adr;
    assign bus_dat_o = req_q.dat;
    assign tmo_o     = tmo_q;

    // Completing cycle bypasses the bus data so the requester is released without an extra stall.
    assign if_rdata_o = ((state_q == ST_IF_BUSY) && done_c) ? rdata_c : if_buf_q;
    assign dm_rdata_o = ((state_q == ST_DM_BUSY) && done_c) ? rdata_c : dm_buf_q;

    assign if_stallreq_o = ~rst & if_req_i & ~flush_i
                         & ~((state_q == ST_IF_BUSY) & done_c)
                         & (state_q != ST_IF_WAIT) & (state_q != ST_IF_DRAIN);
    assign dm_stallreq_o = ~rst & dm_req_i
                         & ~((state_q == ST_DM_BUSY) & done_c)
                         & (state_q != ST_DM_WAIT);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random single-requester
// transactions checked against a latency/data model of each access.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_stallreq_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_stallreq_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        tmo_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave: acks combinationally once stb has been waiting slv_lat cycles.
    int          slv_lat   = 0;
    int          slv_cnt   = 0;
    logic [31:0] slv_rdata = '0;

    always #5 clk = ~clk;

    always_comb bus_ack_i = bus_stb_o && (slv_cnt == slv_lat);
    assign bus_dat_i = slv_rdata;

    always_ff @(posedge clk) begin
        if (bus_stb_o && !bus_ack_i) slv_cnt <= slv_cnt + 1;
        else                         slv_cnt <= 0;
    end

    mem_bus_arbiter #(
        .TMO_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .if_stallreq_o (if_stallreq_o),
        .dm_req_i      (dm_req_i),
        .dm_we_i       (dm_we_i),
        .dm_sel_i      (dm_sel_i),
        .dm_addr_i     (dm_addr_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_rdata_o    (dm_rdata_o),
        .dm_stallreq_o (dm_stallreq_o),
        .bus_cyc_o     (bus_cyc_o),
        .bus_stb_o     (bus_stb_o),
        .bus_we_o      (bus_we_o),
        .bus_sel_o     (bus_sel_o),
        .bus_adr_o     (bus_adr_o),
        .bus_dat_o     (bus_dat_o),
        .bus_dat_i     (bus_dat_i),
        .bus_ack_i     (bus_ack_i),
        .tmo_o         (tmo_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // One access from one requester; expectation: stalled for lat+1 cycles (TMO on timeout),
    // data returned in the release cycle, zero data and a tmo pulse when the slave is too slow.
    task automatic run_txn(input bit is_dm, input bit we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int lat);
        int          k;
        int          es;
        bit          exp_tmo;
        bit          fin;
        logic [31:0] ed;
        logic [31:0] got;
        exp_tmo   = (lat >= TMO);
        es        = exp_tmo ? TMO : lat + 1;
        ed        = exp_tmo ? 32'h0 : rdata;
        slv_lat   = lat;
        slv_rdata = rdata;
        if (is_dm) begin
            dm_req_i   = 1'b1;
            dm_we_i    = we;
            dm_sel_i   = sel;
            dm_addr_i  = addr;
            dm_wdata_i = wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end
        k   = 0;
        fin = 1'b0;
        got = '0;
        for (int c = 0; c < 20; c++) begin
            samp();
            if (k == 1) begin
                chk("txn_stb", 32'(bus_stb_o), 32'd1);
                chk("txn_cyc", 32'(bus_cyc_o), 32'd1);
                chk("txn_adr", bus_adr_o, addr);
                chk("txn_we", 32'(bus_we_o), 32'(is_dm ? we : 1'b0));
                chk("txn_sel", 32'(bus_sel_o), 32'(is_dm ? sel : 4'hF));
                if (is_dm) chk("txn_wdat", bus_dat_o, wdata);
            end
            if ((is_dm ? dm_stallreq_o : if_stallreq_o) == 1'b0) begin
                got = is_dm ? dm_rdata_o : if_rdata_o;
                fin = 1'b1;
                break;
            end
            k++;
            step();
        end
        chk("txn_release", 32'(fin), 32'd1);
        chk("txn_stall_cycles", 32'(k), 32'(es));
        chk("txn_rdata", got, ed);
        step();
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
        if_req_i = 1'b0;
        samp();
        chk("txn_bus_idle", 32'(bus_cyc_o | bus_stb_o), 32'd0);
        chk("txn_tmo", 32'(tmo_o), 32'(exp_tmo));
        chk("txn_buf", is_dm ? dm_rdata_o : if_rdata_o, ed);
        step();
        samp();
        chk("txn_tmo_end", 32'(tmo_o), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r_dm;
        bit          r_we;
        logic [3:0]  r_sel;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [31:0] r_rdata;
        int          r_lat;

        rst        = 1'b1;
        stall_i    = '0;
        flush_i    = 1'b0;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0100;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b0;
        dm_sel_i   = 4'h0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;

        // Reset: everything quiet, stall requests masked even with requests present.
        step();
        step();
        samp();
        chk("rst_if_stall", 32'(if_stallreq_o), 32'd0);
        chk("rst_dm_stall", 32'(dm_stallreq_o), 32'd0);
        chk("rst_cyc", 32'(bus_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus_stb_o), 32'd0);
        chk("rst_adr", bus_adr_o, 32'd0);
        chk("rst_tmo", 32'(tmo_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        step();
        rst      = 1'b0;
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        step();

        // Zero-wait fetch.
        run_txn(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h2408_0001, 0);

        // Simultaneous store and fetch: store first, fetch after one idle cycle.
        slv_lat    = 0;
        slv_rdata  = 32'h1111_2222;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0200;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_sel_i   = 4'hF;
        dm_addr_i  = 32'h0000_0080;
        dm_wdata_i = 32'hDEAD_BEEF;
        samp();
        chk("both_dm_stall0", 32'(dm_stallreq_o), 32'd1);
        chk("both_if_stall0", 32'(if_stallreq_o), 32'd1);
        step();
        samp();
        chk("both_st_stb", 32'(bus_stb_o), 32'd1);
        chk("both_st_we", 32'(bus_we_o), 32'd1);
        chk("both_st_adr", bus_adr_o, 32'h0000_0080);
        chk("both_st_dat", bus_dat_o, 32'hDEAD_BEEF);
        chk("both_dm_stall1", 32'(dm_stallreq_o), 32'd0);
        chk("both_if_stall1", 32'(if_stallreq_o), 32'd1);
        step();
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
        samp();
        chk("both_gap_cyc", 32'(bus_cyc_o), 32'd0);
        chk("both_if_stall2", 32'(if_stallreq_o), 32'd1);
        step();
        samp();
        chk("both_if_stb", 32'(bus_stb_o), 32'd1);
        chk("both_if_we", 32'(bus_we_o), 32'd0);
        chk("both_if_adr", bus_adr_o, 32'h0000_0200);
        chk("both_if_stall3", 32'(if_stallreq_o), 32'd0);
        chk("both_if_rdata", if_rdata_o, 32'h1111_2222);
        step();
        if_req_i = 1'b0;
        samp();
        chk("both_end_cyc", 32'(bus_cyc_o), 32'd0);
        step();

        // Fetch acked while the pipeline is stalled: data held, no stall request.
        slv_lat   = 0;
        slv_rdata = 32'h3333_4444;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0104;
        stall_i   = 6'b000011;
        samp();
        chk("wait_stall0", 32'(if_stallreq_o), 32'd1);
        step();
        samp();
        chk("wait_ack_stall", 32'(if_stallreq_o), 32'd0);
        chk("wait_ack_rdata", if_rdata_o, 32'h3333_4444);
        step();
        samp();
        chk("wait_hold_cyc", 32'(bus_cyc_o), 32'd0);
        chk("wait_hold_stall", 32'(if_stallreq_o), 32'd0);
        chk("wait_hold_rdata", if_rdata_o, 32'h3333_4444);
        step();
        stall_i = '0;
        samp();
        chk("wait_exit_stall", 32'(if_stallreq_o), 32'd0);
        chk("wait_exit_cyc", 32'(bus_cyc_o), 32'd0);
        step();
        if_req_i = 1'b0;
        samp();
        chk("wait_idle_cyc", 32'(bus_cyc_o), 32'd0);
        chk("wait_idle_rdata", if_rdata_o, 32'h3333_4444);
        step();

        // Flush while waiting discards the held instruction.
        slv_rdata = 32'h5555_6666;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0108;
        stall_i   = 6'b000011;
        samp();
        step();
        samp();
        chk("wflush_ack_rdata", if_rdata_o, 32'h5555_6666);
        step();
        flush_i = 1'b1;
        samp();
        chk("wflush_stall", 32'(if_stallreq_o), 32'd0);
        step();
        flush_i  = 1'b0;
        if_req_i = 1'b0;
        stall_i  = '0;
        samp();
        chk("wflush_rdata", if_rdata_o, 32'd0);
        chk("wflush_cyc", 32'(bus_cyc_o), 32'd0);
        step();

        // Flush one cycle into a 3-wait fetch: cycle drains, data dropped, no refetch under flush.
        slv_lat   = 3;
        slv_rdata = 32'hAAAA_5555;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_010C;
        samp();
        chk("drain_stall0", 32'(if_stallreq_o), 32'd1);
        step();
        flush_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            samp();
            chk("drain_stb", 32'(bus_stb_o), 32'd1);
            chk("drain_stall", 32'(if_stallreq_o), 32'd0);
            step();
        end
        samp();
        chk("drain_done_cyc", 32'(bus_cyc_o), 32'd0);
        chk("drain_done_tmo", 32'(tmo_o), 32'd0);
        n_tests++;
        assert (if_rdata_o !== 32'hAAAA_5555) else begin
            n_fail++;
            $error("FAIL drain_discard: observed=%h expected!=%h", if_rdata_o, 32'hAAAA_5555);
        end
        step();
        samp();
        chk("drain_noflush_fetch", 32'(bus_cyc_o), 32'd0);
        step();
        flush_i   = 1'b0;
        slv_lat   = 0;
        slv_rdata = 32'h7777_8888;
        samp();
        chk("drain_refetch_stall", 32'(if_stallreq_o), 32'd1);
        chk("drain_refetch_cyc0", 32'(bus_cyc_o), 32'd0);
        step();
        samp();
        chk("drain_refetch_stb", 32'(bus_stb_o), 32'd1);
        chk("drain_refetch_rdata", if_rdata_o, 32'h7777_8888);
        chk("drain_refetch_rel", 32'(if_stallreq_o), 32'd0);
        step();
        if_req_i = 1'b0;
        step();

        // Slave never answers, and slave answers on the very last allowed cycle.
        run_txn(1'b1, 1'b0, 4'h3, 32'h0000_0040, 32'h0, 32'h1234_5678, 99);
        run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0, 32'h9ABC_DEF0, TMO - 1);

        // Reset in the middle of a data access drops the bus without waiting for ack.
        slv_lat    = 99;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_sel_i   = 4'hC;
        dm_addr_i  = 32'h0000_0090;
        dm_wdata_i = 32'h0F0F_0F0F;
        step();
        rst = 1'b1;
        samp();
        chk("mrst_stb_before", 32'(bus_stb_o), 32'd1);
        chk("mrst_dm_stall", 32'(dm_stallreq_o), 32'd0);
        step();
        samp();
        chk("mrst_cyc", 32'(bus_cyc_o), 32'd0);
        chk("mrst_stb", 32'(bus_stb_o), 32'd0);
        chk("mrst_we", 32'(bus_we_o), 32'd0);
        chk("mrst_sel", 32'(bus_sel_o), 32'd0);
        chk("mrst_adr", bus_adr_o, 32'd0);
        chk("mrst_dat", bus_dat_o, 32'd0);
        chk("mrst_tmo", 32'(tmo_o), 32'd0);
        chk("mrst_dm_rdata", dm_rdata_o, 32'd0);
        step();
        rst      = 1'b0;
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
        samp();
        chk("mrst_idle_cyc", 32'(bus_cyc_o), 32'd0);
        step();

        // Random single-requester accesses with random slave latency, including timeouts.
        for (int i = 0; i < 40; i++) begin
            r_dm    = 1'($urandom_range(0, 1));
            r_we    = r_dm ? 1'($urandom_range(0, 1)) : 1'b0;
            r_sel   = 4'($urandom);
            r_addr  = $urandom & 32'hFFFF_FFFC;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_lat   = int'($urandom_range(0, 5));
            run_txn(r_dm, r_we, r_sel, r_addr, r_wdata, r_rdata, r_lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
